// File: rtl/step_pulse_gen_if.sv
// Button-side bundle of step_pulse_gen: enable and raw button in; step pulse,
// debounced level, busy flag and FSM state out.
interface step_pulse_gen_if;
  logic       ena;
  logic       btn_in;
  logic       step_o;
  logic       btn_level_o;
  logic       busy_o;
  logic [1:0] state_dbg;

  // Driver side (stimulus / upstream control).
  modport master (
    output ena,
    output btn_in,
    input  step_o,
    input  btn_level_o,
    input  busy_o,
    input  state_dbg
  );

  // Pulse generator side.
  modport slave (
    input  ena,
    input  btn_in,
    output step_o,
    output btn_level_o,
    output busy_o,
    output state_dbg
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Push-button to single-cycle step pulse: 2-flop synchroniser, debounce filter,
// press FSM. Define REPEAT_EN to add hold-to-repeat (REPEAT state + repeat counter).
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  step_pulse_gen_if.slave    bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1
  } state_t;
`endif

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            step_q, step_d;
  state_t          state_q, state_d;
  logic            accept;
  logic            rise;
  logic            fall;
`ifdef REPEAT_EN
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // The synchroniser keeps sampling while ena=0 so s2 is current when re-enabled.
  always_comb begin
    s1_d     = bus.btn_in;
    s2_d     = s1_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    accept   = 1'b0;
    if (bus.ena) begin
      if (s2_q != level_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          accept   = 1'b1;
          level_d  = s2_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  assign rise = accept &  s2_q;
  assign fall = accept & ~s2_q;

  // Next state and step pulse; a debounced fall always beats a due repeat pulse.
  always_comb begin
    state_d   = state_q;
    step_d    = 1'b0;
`ifdef REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    if (bus.ena) begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d   = ST_HELD;
            step_d    = 1'b1;
`ifdef REPEAT_EN
            rep_cnt_d = '0;
`endif
          end
        end
        ST_HELD: begin
          if (fall) begin
            state_d   = ST_IDLE;
`ifdef REPEAT_EN
            rep_cnt_d = '0;
          end else if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
            state_d   = ST_REPEAT;
            step_d    = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
          end
        end
`ifdef REPEAT_EN
        ST_REPEAT: begin
          if (fall) begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
            step_d    = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      step_q    <= 1'b0;
      state_q   <= ST_IDLE;
`ifdef REPEAT_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      step_q    <= step_d;
      state_q   <= state_d;
`ifdef REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign bus.step_o      = step_q;
  assign bus.btn_level_o = level_q;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.state_dbg   = state_q;

endmodule
